// File: rtl/sla_pkg.sv
// Shared definitions for the logic-analyser capture path: the capture state
// encoding and the default sample type.
package sla_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE,
    ST_READOUT
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port,
// written so synthesis maps it onto block RAM.
module capture_ram
  import sla_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_W,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem_reg [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/sample_capture.sv
// Capture buffer: stores samples while i_run is high, then streams them out
// over valid/ready. Define SAMPLE_CAPTURE_DECIM_EN to add the i_div prescaler.
module sample_capture
  import sla_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_W,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  internal_reset_n,
  input  logic [WIDTH-1:0]      i_data,
`ifdef SAMPLE_CAPTURE_DECIM_EN
  input  logic [15:0]           i_div,
`endif
  input  logic                  i_run,
  input  logic                  i_clear,
  input  logic                  i_rd_start,
  input  logic                  i_rd_ready,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_last,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(2 ** DEPTH_LOG2);

  cap_state_t             state_reg;
  logic [PTR_W-1:0]       count_reg;
  logic [PTR_W-1:0]       ptr_reg;
  logic                   prime_reg;
  logic                   valid_reg;
  logic                   last_reg;
  logic                   done_reg;
  logic                   ovf_reg;
  logic [WIDTH-1:0]       data_reg;

  logic                   sample_en;
  logic                   room;
  logic                   hs;
  logic                   wr_en;
  logic [DEPTH_LOG2-1:0]  wr_addr;
  logic [DEPTH_LOG2-1:0]  rd_addr;
  logic [WIDTH-1:0]       rd_q;

  assign room = (count_reg < DEPTH_C);
  assign hs   = valid_reg & i_rd_ready;

`ifdef SAMPLE_CAPTURE_DECIM_EN
  logic [15:0] presc_reg;

  // Prescaler is parked at 0 outside a window so the first sample is always taken.
  always_ff @(posedge clk or negedge internal_reset_n) begin
    if (!internal_reset_n) begin
      presc_reg <= '0;
    end else if (i_clear) begin
      presc_reg <= '0;
    end else if (state_reg == ST_CAPTURE) begin
      presc_reg <= (presc_reg >= i_div) ? '0 : presc_reg + 16'd1;
    end else if (state_reg == ST_IDLE && i_run && i_div != 16'd0) begin
      presc_reg <= 16'd1;
    end else begin
      presc_reg <= '0;
    end
  end

  assign sample_en = (presc_reg == 16'd0);
`else
  assign sample_en = 1'b1;
`endif

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    if (!i_clear && i_run && sample_en) begin
      if (state_reg == ST_IDLE) begin
        wr_en = 1'b1;
      end else if (state_reg == ST_CAPTURE && room) begin
        wr_en   = 1'b1;
        wr_addr = count_reg[DEPTH_LOG2-1:0];
      end
    end
  end

  // RAM output always holds the word after the one presented, so a handshake
  // can reload the output register without a bubble.
  always_comb begin
    rd_addr = '0;
    if (valid_reg) begin
      rd_addr = DEPTH_LOG2'(ptr_reg + (hs ? PTR_W'(2) : PTR_W'(1)));
    end else if (prime_reg) begin
      rd_addr = DEPTH_LOG2'(1);
    end
  end

  capture_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (i_data),
    .rd_addr (rd_addr),
    .rd_data (rd_q)
  );

  always_ff @(posedge clk or negedge internal_reset_n) begin
    if (!internal_reset_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      ptr_reg   <= '0;
      prime_reg <= 1'b0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      data_reg  <= '0;
    end else if (i_clear) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      ptr_reg   <= '0;
      prime_reg <= 1'b0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          count_reg <= '0;
          if (i_run) begin
            count_reg <= PTR_W'(1);
            state_reg <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!i_run) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else if (!room) begin
            ovf_reg   <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else if (sample_en) begin
            count_reg <= count_reg + PTR_W'(1);
          end
        end
        ST_DONE: begin
          if (i_rd_start) begin
            state_reg <= ST_READOUT;
            ptr_reg   <= '0;
            prime_reg <= 1'b0;
          end
        end
        ST_READOUT: begin
          if (!valid_reg) begin
            if (!prime_reg) begin
              prime_reg <= 1'b1;
            end else begin
              prime_reg <= 1'b0;
              valid_reg <= 1'b1;
              data_reg  <= rd_q;
              ptr_reg   <= '0;
              last_reg  <= (count_reg == PTR_W'(1));
            end
          end else if (i_rd_ready) begin
            if (last_reg) begin
              state_reg <= ST_IDLE;
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
              count_reg <= '0;
              done_reg  <= 1'b0;
              ovf_reg   <= 1'b0;
              ptr_reg   <= '0;
            end else begin
              data_reg  <= rd_q;
              ptr_reg   <= ptr_reg + PTR_W'(1);
              last_reg  <= (ptr_reg + PTR_W'(2) == count_reg);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_data  = data_reg;
  assign o_rd_valid = valid_reg;
  assign o_rd_last  = last_reg;
  assign o_count    = count_reg;
  assign o_done     = done_reg;
  assign o_overflow = ovf_reg;

endmodule

// File: doc/sample_capture.md
# sample_capture

Capture buffer that sits downstream of `channel_trigger` and consumes its run window. While `i_run` is high, the block writes one `WIDTH`-bit sample per enabled cycle into an internal RAM. After the window closes, it streams the stored samples out to the host-side link over a valid/ready handshake. It is the reader side of the trigger/run interface: the trigger decides *when*, this block stores *what* and hands it back.

## Interface
- `WIDTH`, 8: sample width, matches the trigger's data width
- `DEPTH_LOG2`, 10: buffer depth is `2**DEPTH_LOG2` samples
- `clk` in 1: sole clock, rising edge
- `internal_reset_n` in 1: asynchronous, active-low reset
- `i_data` in `WIDTH`: probed channels, same vector fed to the trigger
- `i_run` in 1: capture window from the trigger's `o_run`
- `i_clear` in 1: synchronous abort/re-arm, returns to IDLE
- `i_rd_start` in 1: start readout, honoured only in DONE
- `i_rd_ready` in 1: host accepts the current word
- `o_rd_data` out `WIDTH`: readout sample
- `o_rd_valid` out 1: `o_rd_data` is valid
- `o_rd_last` out 1: current word is the final stored sample
- `o_count` out `DEPTH_LOG2+1`: number of samples stored
- `o_done` out 1: capture finished, buffer holds data
- `o_overflow` out 1: buffer filled while `i_run` was still high

## Operation
- States: IDLE, CAPTURE, DONE, READOUT.
- IDLE:
  - `i_run`=1: write `i_data` at address 0, set count=1, go to CAPTURE.
  - `i_run`=0: stay, count=0.
- CAPTURE:
  - Each enabled cycle with `i_run`=1 and count<DEPTH: write at address count, then count++.
  - `i_run`=0: go to DONE.
  - count reaches DEPTH with `i_run` still 1: set `o_overflow`, go to DONE. Later samples are dropped; there is no wrap-around.
- DONE:
  - `o_done`=1.
  - `i_run` is ignored.
  - `i_rd_start` goes to READOUT with read pointer 0.
- READOUT:
  - Presents samples 0..count-1 in order.
  - A word advances only on `o_rd_valid && i_rd_ready`.
  - `o_rd_last`=1 when the pointer is count-1.
  - A handshake on the last word returns to IDLE and clears `o_count`, `o_done` and `o_overflow`.
- `i_clear` goes to IDLE from any state and clears the count and flags. It has priority over every other input in the same cycle.
- `i_rd_start` outside DONE is ignored.
- Counter arithmetic is unsigned, `DEPTH_LOG2+1` bits wide, and saturates at DEPTH.

## Timing
- Reset values: all outputs 0, state IDLE, read pointer 0. RAM contents are undefined.
- Capture latency: the sample present on `i_data` in the cycle where `i_run`=1 is sampled is the one stored. `o_count` increments on that same edge.
- `o_done` rises 1 cycle after `i_run` is sampled low in CAPTURE.
- RAM read is synchronous with 1-cycle latency. `o_rd_valid` rises 2 cycles after `i_rd_start` is sampled.
- After a valid handshake, the next word is valid on the following cycle, giving 1 word/cycle sustained when `i_rd_ready` is held high. This requires prefetch/skid of one entry.
- While `o_rd_valid`=1 and `i_rd_ready`=0, `o_rd_data` and `o_rd_last` hold stable. `o_rd_valid` never drops without a handshake, except on `i_clear` or reset.
- Reset asserted mid-operation: immediate IDLE, no partial readout is resumed.

## Configuration
- `SAMPLE_CAPTURE_DECIM_EN` defined:
  - Adds input `i_div` (16 bits).
  - A sample is written only on cycles where a free-running prescaler equals 0.
  - The prescaler counts 0..`i_div`, restarts at 0 on IDLE→CAPTURE, and so the first sample is always taken.
  - `i_div`=0 means every cycle.
- Not defined: no `i_div` port, every cycle in the window is enabled.

## Structure
- Shared package `sla_pkg` holds:
  - The capture state enum.
  - `SAMPLE_W` default.
  - The `sample_t` typedef.
- One sub-module, `capture_ram`: simple dual-port RAM with one write port and one synchronous read port, parameterised by `WIDTH`/`DEPTH_LOG2` so synthesis infers block RAM.
- FSM, counters and readout skid stay in `sample_capture`.

## Test plan
- Basic window:
  - Stimulus: `i_run` high 4 cycles with data 15, 17, 13, 22; then `i_rd_start`, ready held 1.
  - Required: `o_count`=4, `o_done`=1; readout 15, 17, 13, 22 on consecutive cycles, `o_rd_last` on 22, then IDLE with count 0.
- Backpressure:
  - Stimulus: same capture, `i_rd_ready` toggled 1,0,0,1,...
  - Required: each word held stable while ready=0; no word lost or duplicated.
- Overflow:
  - Stimulus: `DEPTH_LOG2`=3, `i_run` high 12 cycles with an incrementing ramp 0..11.
  - Required: count=8, `o_overflow`=1, readout 0..7.
- Clear and reset mid-operation:
  - Stimulus: `i_clear` pulse during READOUT after 2 words; separately, `internal_reset_n` low during CAPTURE.
  - Required: `o_rd_valid`=0 next cycle, all flags 0, state IDLE; a new window recaptures from address 0.
- Ignored inputs:
  - Stimulus: `i_run` re-asserted while in DONE; `i_rd_start` pulsed in IDLE.
  - Required: count unchanged, no readout starts.
- Decimation:
  - Stimulus: `SAMPLE_CAPTURE_DECIM_EN`, `i_div`=2, `i_run` high 9 cycles on a ramp 0..8.
  - Required: stored 0, 3, 6 and count=3.
